// File: rtl/px_downscale2x.sv
// px_downscale2x: 2x2 box-average downscaler for a raster valid/ready pixel
// stream framed by last_x/last_y; odd widths/heights replicate the edge pixel.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   px_in_valid/ready         input beat handshake
//   px_in_data                input pixel (PB bits)
//   px_in_last_x/last_y       input last-of-row / in-last-row flags
//   px_out_valid/ready        output beat handshake
//   px_out_data               averaged pixel (PB bits)
//   px_out_last_x/last_y      output last-of-row / in-last-row flags
//   done                      final output accepted; sticky until rst
module px_downscale2x #(
    parameter int XB = 10,
    parameter int YB = 10,
    parameter int PB = 8
) (
    input  logic          clk,
    input  logic          rst,
    output logic          px_in_ready,
    input  logic          px_in_valid,
    input  logic [PB-1:0] px_in_data,
    input  logic          px_in_last_x,
    input  logic          px_in_last_y,
    input  logic          px_out_ready,
    output logic          px_out_valid,
    output logic          px_out_last_x,
    output logic          px_out_last_y,
    output logic [PB-1:0] px_out_data,
    output logic          done
);

    if (XB < 2 || YB < 1) begin : g_param_check
        $error("px_downscale2x: XB must be >= 2 and YB >= 1");
    end

    localparam int NPAIR = 1 << (XB - 1);
    localparam logic [XB-2:0] PAIR_ONE = 1;
    localparam logic [PB+1:0] ROUND   = 2;

    logic            rst_q;
    logic            x_odd_q,   x_odd_d;
    logic            row_odd_q, row_odd_d;
    logic [PB-1:0]   h0_q,      h0_d;
    logic [XB-2:0]   pair_q,    pair_d;
    logic            out_valid_q, out_valid_d;
    logic [PB-1:0]   out_data_q,  out_data_d;
    logic            out_lx_q,    out_lx_d;
    logic            out_ly_q,    out_ly_d;
    logic            done_q,      done_d;

    // Per-column horizontal pair sums from the even row of the band.
    logic [PB:0]     lbuf_q [NPAIR];

    logic            in_fire;
    logic            out_fire;
    logic            pair_done;
    logic            emit;
    logic            lb_we;
    logic [PB:0]     hsum;
    logic [PB:0]     lbuf_rd;
    logic [PB+1:0]   sum_band;
    logic [PB+1:0]   sum_last;

    assign lbuf_rd = lbuf_q[pair_q];

    always_comb begin
        x_odd_d     = x_odd_q;
        row_odd_d   = row_odd_q;
        h0_d        = h0_q;
        pair_d      = pair_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_lx_d    = out_lx_q;
        out_ly_d    = out_ly_q;
        done_d      = done_q;
        hsum        = '0;
        pair_done   = 1'b0;

        px_in_ready = !rst_q && !done_q && (!out_valid_q || px_out_ready);
        in_fire     = px_in_valid && px_in_ready;
        out_fire    = out_valid_q && px_out_ready;

        if (in_fire) begin
            if (x_odd_q) begin
                hsum      = {1'b0, h0_q} + {1'b0, px_in_data};
                pair_done = 1'b1;
                x_odd_d   = 1'b0;
            end else if (px_in_last_x) begin
                // Odd width: the lone last pixel pairs with itself.
                hsum      = {px_in_data, 1'b0};
                pair_done = 1'b1;
            end else begin
                h0_d      = px_in_data;
                x_odd_d   = 1'b1;
            end

            if (px_in_last_x) begin
                x_odd_d   = 1'b0;
                row_odd_d = px_in_last_y ? 1'b0 : !row_odd_q;
            end

            if (pair_done) begin
                pair_d = px_in_last_x ? '0 : pair_q + PAIR_ONE;
            end
        end

        sum_band = {1'b0, lbuf_rd} + {1'b0, hsum} + ROUND;
        // Odd height: the lone last row pairs with itself.
        sum_last = {hsum, 1'b0} + ROUND;

        emit  = pair_done && (row_odd_q || px_in_last_y);
        lb_we = pair_done && !row_odd_q && !px_in_last_y;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = row_odd_q ? PB'(sum_band >> 2) : PB'(sum_last >> 2);
            out_lx_d    = px_in_last_x;
            out_ly_d    = px_in_last_y;
        end

        if (out_fire && out_lx_q && out_ly_q) begin
            done_d      = 1'b1;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            x_odd_q     <= 1'b0;
            row_odd_q   <= 1'b0;
            h0_q        <= '0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lx_q    <= 1'b0;
            out_ly_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            x_odd_q     <= x_odd_d;
            row_odd_q   <= row_odd_d;
            h0_q        <= h0_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_lx_q    <= out_lx_d;
            out_ly_q    <= out_ly_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we) begin
            lbuf_q[pair_q] <= hsum;
        end
    end

    assign px_out_valid  = out_valid_q;
    assign px_out_data   = out_data_q;
    assign px_out_last_x = out_lx_q;
    assign px_out_last_y = out_ly_q;
    assign done          = done_q;

endmodule

// File: doc/px_downscale2x.md
Name: px_downscale2x

Overview:
- Downstream stage of the 3x3 blur `top` block; consumes its raster output stream (`px_out_*` with `last_x`/`last_y`).
- Produces a 2x2 box-averaged, half-resolution image on an identical valid/ready stream with its own `last_x`/`last_y` and `done`.
- Frame geometry comes only from the input `last_x`/`last_y` flags; there are no cfg ports.
- Odd widths/heights are handled by replicating the edge pixel.

Parameters:
- XB, 10: input x coordinate width; max input width 2^XB.
- YB, 10: input y coordinate width; max input height 2^YB.
- PB, 8: pixel data width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- px_in_ready  out  1  block accepts input beat.
- px_in_valid  in  1  input beat valid.
- px_in_data  in  PB  input pixel.
- px_in_last_x  in  1  input pixel is last of its row.
- px_in_last_y  in  1  input pixel is in last row.
- px_out_ready  in  1  downstream accepts output.
- px_out_valid  out  1  output beat valid.
- px_out_last_x  out  1  output pixel is last of its output row.
- px_out_last_y  out  1  output pixel is in last output row.
- px_out_data  out  PB  averaged pixel.
- done  out  1  final output pixel accepted; sticky until rst.

Behaviour:
- Reset (rst=1 at clk edge): px_out_valid=0, px_out_last_x=0, px_out_last_y=0, px_out_data=0, done=0, px_in_ready=0.
  - Internal state clears: x parity, row parity, held pixel, output register.
  - Line buffer contents are don't-care after reset.
  - Reset mid-frame discards all partial state; the next frame starts at (0,0).
- Input handshake:
  - px_in_ready = !rst_q && !done && (!px_out_valid || px_out_ready); rst_q is the registered rst.
  - Ready is deasserted on the first cycle after reset.
  - A beat transfers when px_in_valid && px_in_ready.
- Horizontal pairing (accepted beats only):
  - Even-x pixel: held in h0.
  - Odd-x pixel: hsum = h0 + p.
  - Even-x pixel with last_x=1 (odd width): hsum = 2*p.
  - hsum is PB+1 bits.
  - x parity resets to even after any last_x beat.
- Row parity: toggles on each accepted last_x beat; resets to even at frame end.
- Line buffer:
  - 2^(XB-1) entries of PB+1 bits, indexed by pair index x>>1.
  - Register array with combinational read; no RAM inference required.
- Even row, pair completed, px_in_last_y=0: write hsum to buf[x>>1]; no output.
- Odd row, pair completed: emit px_out_data = (buf[x>>1] + hsum + 2) >> 2, computed in PB+2 bits.
- Even row, pair completed, px_in_last_y=1 (odd height): emit (2*hsum + 2) >> 2; no buffer write.
- Output register:
  - Loaded on the same edge the completing input beat transfers, so latency is 1 cycle from that beat to px_out_valid.
  - px_out_last_x = input last_x of the completing beat.
  - px_out_last_y = input last_y of the completing beat.
  - Holds data stable while px_out_valid && !px_out_ready.
  - Cleared (valid=0) when accepted and no new result is loaded that cycle.
  - Accept and load in the same cycle gives back-to-back output.
- Throughput: one output per two input beats (per four over a full 2-row band); the output never bubbles when downstream is always ready.
- done:
  - Set on the edge where a beat with px_out_last_x && px_out_last_y is accepted.
  - After done, px_in_ready=0 and px_out_valid=0 until rst.
- Input beats arriving after done are never accepted; the upstream stall is intentional.
- Output dimensions: ceil(W/2) x ceil(H/2) for input W x H, with W,H >= 2.
- Single-pixel rows/columns (W or H = 1) are not supported.

Test Plan:
- 4x4 frame, pixel(x,y) = 4*x + y, both rates 100%:
  - exactly 4 outputs in raster order: 3, 11, 5, 13;
  - last_x on outputs 2 and 4; last_y on outputs 3 and 4;
  - done one cycle after the 4th accept.
- 5x4 frame, column 4 rows 0/1 = 10/11, all other pixels 0 → output (2,0) = 11; output row width 3; last_x on every 3rd output.
- 4x5 frame, row 4 = 7, 9, 0, 0, all other pixels 0 → final output row is 8, 0; last_y set only on those two.
- Constant 255 frame, 1024x24:
  - every output is 255 (no overflow);
  - px_out_ready toggling at a random 30% rate;
  - data/last flags never change while valid && !ready;
  - exactly 512*12 outputs.
- Reset asserted mid-frame after 37 input beats, then a fresh 4x4 frame:
  - no output from the aborted frame appears after reset;
  - new frame results match scenario 1.
- After done, hold px_in_valid=1 for 100 cycles → px_in_ready stays 0, px_out_valid stays 0, done stays 1 until rst.
